// File: rtl/caterr_event_monitor.sv
// Classifies the combined CATERR/RMCA line as a short MCERR pulse or a held IERR level, with sticky flags and BMC irq.
// Optional saturating event counter is built only when CATERR_EVENT_CNT_EN is defined; otherwise oEventCnt is tied to 0.
module caterr_event_monitor #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_WIDTH    = 2,
    parameter int unsigned LEVEL_THRESH = 1000,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iCpuRmcaCatErr_n,
    input  logic                 iClrStatus,
    output logic                 oMcerrSeen,
    output logic                 oIerrSeen,
    output logic                 oCatErrActive,
    output logic                 oEventIrq_n,
    output logic [CNT_WIDTH-1:0] oEventCnt
);

    localparam int unsigned W_W = $clog2(LEVEL_THRESH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [W_W-1:0]         w_q, w_d;
    logic                   mcerr_q, mcerr_d;
    logic                   ierr_q, ierr_d;
    logic                   active_q, active_d;
    logic                   irq_n_q, irq_n_d;
    logic                   s;
    logic                   set_mcerr;
    logic                   set_ierr;

    assign s = sync_q[SYNC_STAGES-1];

    // Width measurement and classification; set beats a coincident clear.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], iCpuRmcaCatErr_n};
        state_d   = state_q;
        w_d       = w_q;
        set_mcerr = 1'b0;
        set_ierr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_LOW;
                    w_d     = W_W'(1);
                end else begin
                    w_d = '0;
                end
            end
            ST_LOW: begin
                if (!s) begin
                    w_d = w_q + W_W'(1);
                    if (w_d == W_W'(LEVEL_THRESH)) begin
                        state_d  = ST_HOLD;
                        set_ierr = 1'b1;
                    end
                end else begin
                    set_mcerr = (w_q >= W_W'(MIN_WIDTH));
                    state_d   = ST_IDLE;
                    w_d       = '0;
                end
            end
            ST_HOLD: begin
                if (s) begin
                    state_d = ST_IDLE;
                    w_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                w_d     = '0;
            end
        endcase
        mcerr_d  = set_mcerr | (mcerr_q & ~iClrStatus);
        ierr_d   = set_ierr  | (ierr_q  & ~iClrStatus);
        active_d = (state_d != ST_IDLE);
        irq_n_d  = ~(mcerr_q | ierr_q);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync_q   <= '1;
            state_q  <= ST_IDLE;
            w_q      <= '0;
            mcerr_q  <= 1'b0;
            ierr_q   <= 1'b0;
            active_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            w_q      <= w_d;
            mcerr_q  <= mcerr_d;
            ierr_q   <= ierr_d;
            active_q <= active_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign oMcerrSeen    = mcerr_q;
    assign oIerrSeen     = ierr_q;
    assign oCatErrActive = active_q;
    assign oEventIrq_n   = irq_n_q;

`ifdef CATERR_EVENT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 evt;

    // Saturating event count; a clear coinciding with an event leaves 1.
    always_comb begin
        evt   = set_mcerr | set_ierr;
        cnt_d = cnt_q;
        if (iClrStatus) begin
            cnt_d = evt ? CNT_WIDTH'(1) : '0;
        end else if (evt && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oEventCnt = cnt_q;
`else
    assign oEventCnt = '0;
`endif

endmodule

// File: tb/tb_caterr_event_monitor.sv
// Randomized and directed bench for caterr_event_monitor against a run-length reference model.
module tb_caterr_event_monitor;

    localparam int unsigned SYNC = 2;
    localparam int unsigned MINW = 2;
    localparam int unsigned THR  = 1000;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = (1 << CW) - 1;
`ifdef CATERR_EVENT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pin;
    logic          clr;
    logic          mcerr_o;
    logic          ierr_o;
    logic          active_o;
    logic          irq_n_o;
    logic [CW-1:0] cnt_o;

    always #5 clk = ~clk;

    caterr_event_monitor #(
        .SYNC_STAGES (SYNC),
        .MIN_WIDTH   (MINW),
        .LEVEL_THRESH(THR),
        .CNT_WIDTH   (CW)
    ) dut (
        .iClk            (clk),
        .iRst_n          (rst_n),
        .iCpuRmcaCatErr_n(pin),
        .iClrStatus      (clr),
        .oMcerrSeen      (mcerr_o),
        .oIerrSeen       (ierr_o),
        .oCatErrActive   (active_o),
        .oEventIrq_n     (irq_n_o),
        .oEventCnt       (cnt_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history, length of the current low run, flags and count.
    bit hist[$];
    int run;
    bit m_mcerr, m_ierr, m_irq_n, m_active;
    int m_cnt;

    function automatic int cnt_exp(input int n);
        if (!CNT_ON) return 0;
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic model_edge(input bit p, input bit c, input bit r_n);
        bit s, ev_m, ev_i;
        if (!r_n) begin
            hist = {};
            for (int i = 0; i < int'(SYNC); i++) hist.push_back(1'b1);
            run = 0; m_mcerr = 0; m_ierr = 0; m_irq_n = 1; m_active = 0; m_cnt = 0;
            return;
        end
        s = hist.pop_front();
        hist.push_back(p);
        ev_m = 0;
        ev_i = 0;
        if (!s) begin
            run++;
            if (run == int'(THR)) ev_i = 1;
        end else begin
            if (run >= int'(MINW) && run < int'(THR)) ev_m = 1;
            run = 0;
        end
        m_irq_n = !(m_mcerr || m_ierr);
        m_mcerr = ev_m || (m_mcerr && !c);
        m_ierr  = ev_i || (m_ierr && !c);
        if (CNT_ON) begin
            if (c) m_cnt = (ev_m || ev_i) ? 1 : 0;
            else if ((ev_m || ev_i) && m_cnt < CMAX) m_cnt++;
        end
        m_active = (run > 0);
    endtask

    task automatic step(input bit p, input bit c);
        pin = p;
        clr = c;
        @(posedge clk);
        model_edge(p, c, rst_n);
        @(negedge clk);
        chk("mcerr", 32'(mcerr_o), 32'(m_mcerr));
        chk("ierr", 32'(ierr_o), 32'(m_ierr));
        chk("active", 32'(active_o), 32'(m_active));
        chk("irq_n", 32'(irq_n_o), 32'(m_irq_n));
        chk("cnt", 32'(cnt_o), 32'(m_cnt));
    endtask

    task automatic pulse(input int w);
        repeat (w) step(1'b0, 1'b0);
        repeat (SYNC + 2) step(1'b1, 1'b0);
    endtask

    task automatic clear_all();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        int first;
        rst_n = 1'b0;
        pin   = 1'b1;
        clr   = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;

        // Quiet line
        repeat (5000) step(1'b1, 1'b0);
        chk("quiet_irq", 32'(irq_n_o), 32'd1);
        chk("quiet_mcerr", 32'(mcerr_o), 32'd0);
        chk("quiet_cnt", 32'(cnt_o), 32'd0);

        // One-cycle glitch is ignored
        pulse(1);
        chk("glitch_mcerr", 32'(mcerr_o), 32'd0);
        chk("glitch_cnt", 32'(cnt_o), 32'd0);

        // 20-cycle MCERR with exact latency
        repeat (20) step(1'b0, 1'b0);
        repeat (SYNC) step(1'b1, 1'b0);
        chk("mcerr_early", 32'(mcerr_o), 32'd0);
        step(1'b1, 1'b0);
        chk("mcerr_set", 32'(mcerr_o), 32'd1);
        chk("mcerr_irq_hold", 32'(irq_n_o), 32'd1);
        step(1'b1, 1'b0);
        chk("mcerr_irq_fall", 32'(irq_n_o), 32'd0);
        chk("mcerr_cnt", 32'(cnt_o), 32'(cnt_exp(1)));
        step(1'b1, 1'b1);
        chk("clr_mcerr", 32'(mcerr_o), 32'd0);
        step(1'b1, 1'b0);
        chk("clr_irq_rise", 32'(irq_n_o), 32'd1);
        chk("clr_cnt", 32'(cnt_o), 32'd0);

        // Held low: IERR exactly at threshold
        for (int i = 1; i <= 1500; i++) begin
            step(1'b0, 1'b0);
            if (i == int'(SYNC + THR) - 1) chk("ierr_early", 32'(ierr_o), 32'd0);
            if (i == int'(SYNC + THR)) chk("ierr_at_thr", 32'(ierr_o), 32'd1);
        end
        chk("ierr_no_mcerr", 32'(mcerr_o), 32'd0);
        chk("ierr_cnt", 32'(cnt_o), 32'(cnt_exp(1)));
        repeat (10) step(1'b1, 1'b0);
        chk("ierr_release_cnt", 32'(cnt_o), 32'(cnt_exp(1)));
        step(1'b1, 1'b1);
        chk("ierr_clr", 32'(ierr_o), 32'd0);
        step(1'b1, 1'b0);
        chk("ierr_clr_irq", 32'(irq_n_o), 32'd1);

        // Threshold boundary
        pulse(int'(THR) - 1);
        chk("thr_m1_mcerr", 32'(mcerr_o), 32'd1);
        chk("thr_m1_ierr", 32'(ierr_o), 32'd0);
        clear_all();
        pulse(int'(THR));
        chk("thr_ierr", 32'(ierr_o), 32'd1);
        chk("thr_mcerr", 32'(mcerr_o), 32'd0);
        clear_all();

        // Clear coincident with MCERR classification
        repeat (20) step(1'b0, 1'b0);
        repeat (SYNC) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("setclr_mcerr", 32'(mcerr_o), 32'd1);
        chk("setclr_cnt", 32'(cnt_o), 32'(cnt_exp(1)));
        clear_all();

        // Saturation
        repeat (300) begin
            repeat (3) step(1'b0, 1'b0);
            repeat (3) step(1'b1, 1'b0);
        end
        repeat (SYNC + 2) step(1'b1, 1'b0);
        chk("sat_cnt", 32'(cnt_o), 32'(cnt_exp(300)));
        clear_all();

        // Reset in the middle of a held low
        repeat (500 + SYNC) step(1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) begin
            step(1'b0, 1'b1);
            chk("rst_active", 32'(active_o), 32'd0);
        end
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= int'(THR + SYNC) + 50; n++) begin
            step(1'b0, 1'b0);
            if (first == 0 && ierr_o === 1'b1) first = n;
        end
        chk("rst_ierr_latency", 32'(first), 32'(SYNC + THR));
        repeat (10) step(1'b1, 1'b0);
        clear_all();

        // Random pulses, gaps and clear strobes
        repeat (60) begin
            int sel, w, g;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      w = int'($urandom_range(1, MINW - 1));
            else if (sel < 7) w = int'($urandom_range(MINW, 60));
            else if (sel < 9) w = int'($urandom_range(THR - 2, THR + 2));
            else              w = int'($urandom_range(THR + 3, THR + 100));
            g = int'($urandom_range(1, 8));
            repeat (w) step(1'b0, $urandom_range(0, 15) == 0);
            repeat (g) step(1'b1, $urandom_range(0, 7) == 0);
        end
        repeat (SYNC + 3) step(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
